acc_rmw_ctrl: RTL and testbench
===============================

ACC_RMW_CTRL -- requirements
Module: acc_rmw_ctrl

Interface
REQ-001 The block SHALL have parameter BIT_ADDR_ACC, default 19, giving the counter width in bits.
REQ-002 The block SHALL have parameter BIT_BIN, default 10, giving the bin-address width; depth is 2^BIT_BIN.
REQ-003 The block SHALL have the following ports, one per line (name, direction, width, meaning):
- clk  in  1  single clock; all state on the rising edge.
- clr_n  in  1  asynchronous, active-low reset.
- start_clear  in  1  one-cycle request to zero all bins.
- sample_valid  in  1  sample offered.
- sample_bin  in  BIT_BIN  bin to increment.
- sample_ready  out  1  sample accepted when valid && ready.
- ram_re  out  1  RAM read enable.
- ram_raddr  out  BIT_BIN  RAM read address.
- ram_rdata  in  BIT_ADDR_ACC  RAM read data; 1-cycle latency; read-during-write returns the old value.
- ram_we  out  1  RAM write enable.
- ram_waddr  out  BIT_BIN  RAM write address.
- ram_wdata  out  BIT_ADDR_ACC  RAM write data.
- busy  out  1  high in CLEAR or DRAIN.
- clear_done  out  1  one-cycle pulse when a clear sweep completes.
- sat_flag  out  1  sticky; a bin saturated since the last clear.

Function
REQ-004 The FSM SHALL have states CLEAR, RUN and DRAIN.
REQ-005 The FSM SHALL leave reset in CLEAR with sweep address 0.
REQ-006 sample_ready SHALL be combinational and equal (state==RUN && !start_clear).
REQ-007 On sample accept at cycle t (stage S0), ram_re SHALL be 1 and ram_raddr SHALL be sample_bin in cycle t; otherwise ram_re SHALL be 0.
REQ-008 In cycle t+1 (stage S1, registered bin and valid), the block SHALL form old = forwarded value or ram_rdata, and new = (old == 2^BIT_ADDR_ACC-1) ? old : old+1.
REQ-009 In cycle t+2 (stage W, registered), the block SHALL drive ram_we=1, ram_waddr=bin and ram_wdata=new; write latency from accept to ram_we is 2 cycles.
REQ-010 Forwarding SHALL use two registers: W (the write issued this cycle) and W2 (the write issued the previous cycle).
REQ-011 In S1, old SHALL be W data if W is valid with a matching bin; otherwise W2 data if W2 is valid with a matching bin; otherwise ram_rdata.
REQ-012 The pipeline SHALL accept one sample per cycle with no bubbles, including back-to-back samples to the same bin.
REQ-013 The block SHALL set sat_flag when a saturated bin is incremented (old at max); the count SHALL hold at max and never wrap.
REQ-014 start_clear in RUN SHALL move the FSM to DRAIN; DRAIN SHALL hold until S1 and W are both empty, then go to CLEAR.
REQ-015 A sample offered in the same cycle as start_clear SHALL NOT be accepted.
REQ-016 In CLEAR, the block SHALL write zero to addresses 0 through 2^BIT_BIN-1, one per cycle (ram_we=1, ram_wdata=0), with ram_re=0.
REQ-017 After the write to the last address, clear_done SHALL pulse in the next cycle, and the FSM SHALL enter RUN in that same cycle with sat_flag cleared.
REQ-018 start_clear while in CLEAR SHALL restart the sweep at address 0, with no clear_done pulse for the aborted sweep.
REQ-019 start_clear in DRAIN SHALL have no additional effect.
REQ-020 The block SHALL invalidate W and W2 on entry to CLEAR, so that zero-writes are never forwarded as counts.

Reset
REQ-021 When clr_n is low, the block SHALL asynchronously force state=CLEAR, sweep address=0, and all pipeline valids, W and W2 to 0.
REQ-022 When clr_n is low, ram_we, ram_re, clear_done and sat_flag SHALL be 0, and busy SHALL be 1.
REQ-023 Reset asserted mid-pipeline SHALL drop all in-flight increments; the following sweep restores a consistent all-zero memory.

Structure
REQ-024 A shared package SHALL hold the state enumeration (CLEAR, RUN, DRAIN) and the default BIT_ADDR_ACC and BIT_BIN constants.
REQ-025 The saturating increment plus forwarding mux SHALL be one sub-module, acc_fwd_inc; the FSM and pipeline registers SHALL stay in the top module.

Verification
REQ-026 Reset release with BIT_BIN=3 -> 8 zero-writes to addresses 0..7 on consecutive cycles, clear_done pulses once, sample_ready rises in the same cycle.
REQ-027 Samples to bins 5,5,5,5 on consecutive cycles from empty -> writes to bin 5 of 1,2,3,4 at 2..5 cycles after the first accept.
REQ-028 Samples 2,3,2 back-to-back (exercises W2 forwarding) -> final writes are bin 2 = 1, bin 3 = 1, bin 2 = 2.
REQ-029 Bin 1 preloaded to 2^19-2, then 3 samples to bin 1 -> writes of 2^19-1, 2^19-1, 2^19-1; sat_flag set after the second increment and held.
REQ-030 start_clear during a stream of 4 samples -> sample_ready drops in the same cycle, the 2 in-flight writes complete, then the sweep runs and clear_done pulses and sat_flag clears.
REQ-031 clr_n low for 1 cycle mid-pipeline -> ram_we drops immediately; after release the sweep restarts at address 0.

Source files
------------

// File: rtl/acc_rmw_ctrl_pkg.sv
// Shared types and default sizes for the histogram read-modify-write controller.
// Latency: none (declarations only); backpressure: n/a.
package acc_rmw_ctrl_pkg;

  localparam int DEF_BIT_ADDR_ACC = 19;
  localparam int DEF_BIT_BIN      = 10;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/acc_rmw_ctrl_fwd_inc.sv
// Picks the freshest count for a bin (W, then W2, then RAM) and saturating-increments it.
// Latency: combinational; backpressure: none.
module acc_fwd_inc
  import acc_rmw_ctrl_pkg::*;
#(
  parameter int BIT_ADDR_ACC = DEF_BIT_ADDR_ACC,
  parameter int BIT_BIN      = DEF_BIT_BIN
) (
  input  logic [BIT_BIN-1:0]      i_s1_bin,
  input  logic [BIT_ADDR_ACC-1:0] i_ram_rdata,
  input  logic                    i_w_vld,
  input  logic [BIT_BIN-1:0]      i_w_bin,
  input  logic [BIT_ADDR_ACC-1:0] i_w_dat,
  input  logic                    i_w2_vld,
  input  logic [BIT_BIN-1:0]      i_w2_bin,
  input  logic [BIT_ADDR_ACC-1:0] i_w2_dat,
  output logic [BIT_ADDR_ACC-1:0] o_new_dat,
  output logic                    o_sat
);

  logic [BIT_ADDR_ACC-1:0] w_old;

  // W is newer than W2, so it wins when both hit the same bin.
  always_comb begin
    w_old = i_ram_rdata;
    if (i_w_vld && (i_w_bin == i_s1_bin)) begin
      w_old = i_w_dat;
    end else if (i_w2_vld && (i_w2_bin == i_s1_bin)) begin
      w_old = i_w2_dat;
    end
  end

  assign o_sat     = &w_old;
  assign o_new_dat = o_sat ? w_old : (w_old + BIT_ADDR_ACC'(1));

endmodule

// File: rtl/acc_rmw_ctrl.sv
// Histogram bin counter: read-modify-write over a 1-cycle RAM with clear sweep.
// Latency: accept to RAM write 2 cycles; backpressure: sample_ready low outside RUN or when start_clear.
module acc_rmw_ctrl
  import acc_rmw_ctrl_pkg::*;
#(
  parameter int BIT_ADDR_ACC = DEF_BIT_ADDR_ACC,
  parameter int BIT_BIN      = DEF_BIT_BIN
) (
  input  logic                    clk,
  input  logic                    clr_n,
  input  logic                    start_clear,
  input  logic                    sample_valid,
  input  logic [BIT_BIN-1:0]      sample_bin,
  output logic                    sample_ready,
  output logic                    ram_re,
  output logic [BIT_BIN-1:0]      ram_raddr,
  input  logic [BIT_ADDR_ACC-1:0] ram_rdata,
  output logic                    ram_we,
  output logic [BIT_BIN-1:0]      ram_waddr,
  output logic [BIT_ADDR_ACC-1:0] ram_wdata,
  output logic                    busy,
  output logic                    clear_done,
  output logic                    sat_flag
);

  typedef struct packed {
    logic               vld;
    logic [BIT_BIN-1:0] bin;
  } s1_t;

  typedef struct packed {
    logic                    vld;
    logic [BIT_BIN-1:0]      bin;
    logic [BIT_ADDR_ACC-1:0] dat;
  } wr_t;

  localparam logic [BIT_BIN-1:0] LAST_BIN = '1;

  state_t             r_state;
  logic [BIT_BIN-1:0] r_addr;
  logic               r_clr_act;
  s1_t                r_s1;
  wr_t                r_w;
  wr_t                r_w2;
  logic               r_done;
  logic               r_sat;

  logic                    w_accept;
  logic                    w_sweep;
  logic [BIT_ADDR_ACC-1:0] w_new;
  logic                    w_sat;

  assign sample_ready = (r_state == ST_RUN) && !start_clear;
  assign w_accept     = sample_valid && sample_ready;
  assign ram_re       = w_accept;
  assign ram_raddr    = sample_bin;

  // r_clr_act holds the sweep off for the first cycle out of reset so ram_we stays low in reset.
  assign w_sweep   = (r_state == ST_CLEAR) && r_clr_act;
  assign ram_we    = w_sweep || r_w.vld;
  assign ram_waddr = w_sweep ? r_addr : r_w.bin;
  assign ram_wdata = w_sweep ? '0 : r_w.dat;

  assign busy       = (r_state != ST_RUN);
  assign clear_done = r_done;
  assign sat_flag   = r_sat;

  acc_fwd_inc #(
    .BIT_ADDR_ACC (BIT_ADDR_ACC),
    .BIT_BIN      (BIT_BIN)
  ) u_fwd_inc (
    .i_s1_bin    (r_s1.bin),
    .i_ram_rdata (ram_rdata),
    .i_w_vld     (r_w.vld),
    .i_w_bin     (r_w.bin),
    .i_w_dat     (r_w.dat),
    .i_w2_vld    (r_w2.vld),
    .i_w2_bin    (r_w2.bin),
    .i_w2_dat    (r_w2.dat),
    .o_new_dat   (w_new),
    .o_sat       (w_sat)
  );

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_state   <= ST_CLEAR;
      r_addr    <= '0;
      r_clr_act <= 1'b0;
      r_s1      <= '0;
      r_w       <= '0;
      r_w2      <= '0;
      r_done    <= 1'b0;
      r_sat     <= 1'b0;
    end else begin
      r_clr_act <= 1'b1;
      r_done    <= 1'b0;
      r_s1.vld  <= w_accept;
      r_s1.bin  <= sample_bin;
      r_w.vld   <= r_s1.vld;
      r_w.bin   <= r_s1.bin;
      r_w.dat   <= w_new;
      r_w2      <= r_w;
      if (r_s1.vld && w_sat) begin
        r_sat <= 1'b1;
      end

      case (r_state)
        ST_RUN: begin
          if (start_clear) begin
            r_state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (!r_s1.vld && !r_w.vld) begin
            r_state <= ST_CLEAR;
            r_addr  <= '0;
            r_w2    <= '0;
          end
        end
        ST_CLEAR: begin
          // Zero-writes must never feed the forwarding path.
          r_w  <= '0;
          r_w2 <= '0;
          if (start_clear) begin
            r_addr <= '0;
          end else if (r_clr_act) begin
            if (r_addr == LAST_BIN) begin
              r_state <= ST_RUN;
              r_addr  <= '0;
              r_done  <= 1'b1;
              r_sat   <= 1'b0;
            end else begin
              r_addr <= r_addr + BIT_BIN'(1);
            end
          end
        end
        default: begin
          r_state <= ST_CLEAR;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_acc_rmw_ctrl.sv
// Bench for acc_rmw_ctrl: bin-count model, write scoreboard, sweep tracker, directed + random traffic.
module tb_acc_rmw_ctrl;

  localparam int ACC = 19;
  localparam int BIN = 3;
  localparam int NB  = 8;
  localparam logic [ACC-1:0] MAXV = '1;

  logic           clk          = 1'b0;
  logic           clr_n        = 1'b0;
  logic           start_clear  = 1'b0;
  logic           sample_valid = 1'b0;
  logic [BIN-1:0] sample_bin   = '0;
  logic           sample_ready, ram_re, ram_we, busy, clear_done, sat_flag;
  logic [BIN-1:0] ram_raddr, ram_waddr;
  logic [ACC-1:0] ram_rdata, ram_wdata;

  logic           pre_en   = 1'b0;
  logic [BIN-1:0] pre_addr = '0;
  logic [ACC-1:0] pre_val  = '0;
  logic [ACC-1:0] mem [NB];

  always #5 clk = ~clk;

  acc_rmw_ctrl #(.BIT_ADDR_ACC(ACC), .BIT_BIN(BIN)) dut (
    .clk          (clk),
    .clr_n        (clr_n),
    .start_clear  (start_clear),
    .sample_valid (sample_valid),
    .sample_bin   (sample_bin),
    .sample_ready (sample_ready),
    .ram_re       (ram_re),
    .ram_raddr    (ram_raddr),
    .ram_rdata    (ram_rdata),
    .ram_we       (ram_we),
    .ram_waddr    (ram_waddr),
    .ram_wdata    (ram_wdata),
    .busy         (busy),
    .clear_done   (clear_done),
    .sat_flag     (sat_flag)
  );

  // 1-cycle RAM; a read colliding with a write returns the old word.
  always @(posedge clk) begin
    if (ram_we) mem[ram_waddr] <= ram_wdata;
    if (pre_en) mem[pre_addr] <= pre_val;
    if (ram_re) ram_rdata <= mem[ram_raddr];
  end

  // ---------------- model + compare ----------------
  typedef struct { int due; int bin; longint val; } wexp_t;

  int n_tests = 0, n_fail = 0;
  int cyc = 0;
  logic [ACC-1:0] ref_cnt [NB];
  wexp_t wq[$];
  int    satq[$];
  bit    run_m = 0, sat_m = 0, prev7 = 0;
  int    sweep_exp = 0, sweep_cnt = 0, n_done = 0, n_sw = 0;
  int    wl_cyc[$], wl_bin[$], acc_cyc[$];
  longint wl_val[$];
  bit    wl_sat[$];
  int    lit_phase = 0, seen_phase = 0, tmo_cnt = 0, seen_tmo = 0;
  int    base_w = 0, base_a = 0, base_done = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0d expected %0d", nm, cyc, act, exp);
    end
  endtask

  task automatic lit_w(input string nm, input int k, input int bin, input longint val);
    if (wl_bin.size() > base_w + k) begin
      chk({nm, "_bin"}, wl_bin[base_w + k], bin);
      chk({nm, "_val"}, wl_val[base_w + k], val);
    end
  endtask

  always @(negedge clk) begin
    bit acc, exp_done;
    int nz;
    wexp_t e;
    cyc++;
    if (!clr_n) begin
      chk("rst_we", ram_we, 0);
      chk("rst_re", ram_re, 0);
      chk("rst_done", clear_done, 0);
      chk("rst_sat", sat_flag, 0);
      chk("rst_busy", busy, 1);
      wq.delete(); satq.delete();
      run_m = 0; sat_m = 0; prev7 = 0; sweep_exp = 0; sweep_cnt = 0;
    end else begin
      exp_done = prev7;
      prev7 = 0;
      chk("clear_done", clear_done, exp_done);
      if (exp_done) begin
        n_done++; run_m = 1; sat_m = 0; nz = 0;
        for (int i = 0; i < NB; i++) begin
          if (mem[i] != '0) nz++;
          ref_cnt[i] = '0;
        end
        chk("mem_zero_after_sweep", nz, 0);
      end
      if (pre_en) ref_cnt[pre_addr] = pre_val;
      while (satq.size() > 0 && satq[0] == cyc) begin
        sat_m = 1;
        void'(satq.pop_front());
      end
      chk("sat_flag", sat_flag, sat_m);
      chk("sample_ready", sample_ready, run_m && !start_clear);
      chk("busy", busy, !run_m);

      acc = sample_valid && run_m && !start_clear;
      chk("ram_re", ram_re, acc);
      if (acc) begin
        chk("ram_raddr", ram_raddr, sample_bin);
        acc_cyc.push_back(cyc);
        if (ref_cnt[sample_bin] == MAXV) satq.push_back(cyc + 2);
        else ref_cnt[sample_bin] = ref_cnt[sample_bin] + 19'd1;
        e.due = cyc + 2; e.bin = int'(sample_bin); e.val = longint'(ref_cnt[sample_bin]);
        wq.push_back(e);
      end

      if (wq.size() > 0 && wq[0].due == cyc) begin
        chk("inc_we", ram_we, 1);
        chk("inc_waddr", ram_waddr, wq[0].bin);
        chk("inc_wdata", ram_wdata, wq[0].val);
        wl_cyc.push_back(cyc); wl_bin.push_back(int'(ram_waddr));
        wl_val.push_back(longint'(ram_wdata)); wl_sat.push_back(sat_flag);
        void'(wq.pop_front());
      end else if (ram_we) begin
        n_sw++;
        chk("sweep_wdata", ram_wdata, 0);
        chk("sweep_waddr", ram_waddr, sweep_exp);
        if (start_clear) begin
          sweep_exp = 0; sweep_cnt = 0;
        end else begin
          sweep_cnt++;
          if (sweep_exp == NB - 1) begin
            prev7 = (sweep_cnt == NB);
            sweep_exp = 0; sweep_cnt = 0;
          end else begin
            sweep_exp++;
          end
        end
      end else if (sweep_cnt != 0) begin
        chk("sweep_gap_we", ram_we, 1);
      end
      if (start_clear && run_m) run_m = 0;

      if (lit_phase != seen_phase) begin
        case (lit_phase)
          1: begin
            chk("A_done_pulses", n_done, 1);
            chk("A_sweep_writes", n_sw, 8);
            chk("A_ready_with_done", sample_ready, 1);
          end
          2: begin
            chk("B_nwrites", wl_bin.size() - base_w, 4);
            for (int k = 0; k < 4; k++) begin
              lit_w("B", k, 5, k + 1);
              if (wl_cyc.size() > base_w + k && acc_cyc.size() > base_a)
                chk("B_latency", wl_cyc[base_w + k] - acc_cyc[base_a], k + 2);
            end
          end
          3: begin
            chk("C_nwrites", wl_bin.size() - base_w, 3);
            lit_w("C0", 0, 2, 1); lit_w("C1", 1, 3, 1); lit_w("C2", 2, 2, 2);
          end
          4: begin
            chk("D_nwrites", wl_bin.size() - base_w, 3);
            for (int k = 0; k < 3; k++) lit_w("D", k, 1, 524287);
            if (wl_sat.size() >= base_w + 3) begin
              chk("D_sat_w0", wl_sat[base_w], 0);
              chk("D_sat_w1", wl_sat[base_w + 1], 1);
              chk("D_sat_w2", wl_sat[base_w + 2], 1);
            end
            chk("D_sat_held", sat_flag, 1);
            chk("D_mem1", mem[1], 524287);
          end
          5: begin
            chk("E_nwrites", wl_bin.size() - base_w, 2);
            lit_w("E0", 0, 6, 1); lit_w("E1", 1, 7, 1);
            chk("E_done_pulses", n_done - base_done, 1);
            chk("E_sat_cleared", sat_flag, 0);
          end
          6: begin
            chk("F_nwrites", wl_bin.size() - base_w, 0);
            chk("F_done_pulses", n_done - base_done, 1);
          end
          default: ;
        endcase
        base_w = wl_bin.size(); base_a = acc_cyc.size(); base_done = n_done;
        seen_phase = lit_phase;
      end
      if (tmo_cnt != seen_tmo) begin
        chk("wait_timeout", tmo_cnt, seen_tmo);
        seen_tmo = tmo_cnt;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!clear_done && n < 200) begin tick(); n++; end
    if (!clear_done) tmo_cnt++;
  endtask

  task automatic send(input int b);
    sample_valid = 1'b1; sample_bin = BIN'(b);
    tick();
    sample_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #2 clr_n = 1'b1;
    tick();
    wait_done();
    lit_phase = 1;
    tick();

    for (int i = 0; i < 4; i++) begin sample_valid = 1'b1; sample_bin = 3'd5; tick(); end
    sample_valid = 1'b0; idle(4);
    lit_phase = 2;
    tick();

    send(2); send(3); send(2);
    idle(4);
    lit_phase = 3;
    tick();

    pre_en = 1'b1; pre_addr = 3'd1; pre_val = MAXV - 19'd1;
    tick();
    pre_en = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin sample_valid = 1'b1; sample_bin = 3'd1; tick(); end
    sample_valid = 1'b0; idle(4);
    lit_phase = 4;
    tick();

    sample_valid = 1'b1; sample_bin = 3'd6; tick();
    sample_bin = 3'd7; tick();
    sample_bin = 3'd0; start_clear = 1'b1; tick();
    start_clear = 1'b0; sample_bin = 3'd1; tick();
    sample_valid = 1'b0;
    wait_done();
    lit_phase = 5;
    tick();

    sample_valid = 1'b1; sample_bin = 3'd4; tick();
    tick();
    #1 clr_n = 1'b0;
    sample_valid = 1'b0;
    @(posedge clk); #2 clr_n = 1'b1;
    tick();
    wait_done();
    lit_phase = 6;
    tick();

    for (int i = 0; i < 3000; i++) begin
      if (clear_done) begin
        sample_valid = 1'b0; start_clear = 1'b0;
        pre_en = 1'b1; pre_addr = BIN'($urandom_range(0, NB - 1));
        pre_val = MAXV - 19'($urandom_range(0, 2));
      end else begin
        pre_en = 1'b0;
        sample_valid = ($urandom_range(0, 3) != 0);
        sample_bin = BIN'($urandom_range(0, NB - 1));
        start_clear = ($urandom_range(0, 249) == 0);
      end
      tick();
    end
    pre_en = 1'b0; sample_valid = 1'b0;
    start_clear = 1'b1; tick();
    start_clear = 1'b0;
    wait_done();
    idle(3);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
